// File: rtl/flash_ctrl.sv
// flash_ctrl: sequences CPU read/program/erase requests onto the flash macro command interface.
// Defining FLASH_CTRL_VERIFY_EN adds a read-back verify after every program.
module flash_ctrl #(
    parameter int WAIT_CYC = 3,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_op,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              fl_rd_en,
    output logic              fl_wr_en,
    output logic              fl_erase_en,
    output logic [ADDR_W-1:0] fl_addr,
    output logic [31:0]       fl_idata,
    input  logic [31:0]       fl_odata,
    input  logic              fl_busy,
    input  logic              fl_error
);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_PROG  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        ISSUE,
        WAIT,
`ifdef FLASH_CTRL_VERIFY_EN
        VF_ISSUE,
        VF_WAIT,
`endif
        DONE
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [1:0] op_q;
    logic       err_acc, err_next;
    logic       take;
    logic       rd_capture;
    logic       vf_pulse;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_next   = err_acc;
        take       = 1'b0;
        rd_capture = 1'b0;
        case (state)
            // Flash may still be finishing an operation from before reset.
            RST_HOLD: begin
                if (cnt == 4'd0) state_next = IDLE;
                else             cnt_next   = cnt - 4'd1;
            end
            IDLE: begin
                if (cpu_req && !fl_busy) begin
                    take = 1'b1;
                    if (cpu_addr[1:0] != 2'b00 || cpu_op == OP_NONE) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b0;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = WAIT_INIT;
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (fl_error) err_next = 1'b1;
                if (cnt == 4'd1) begin
                    rd_capture = (op_q == OP_READ);
`ifdef FLASH_CTRL_VERIFY_EN
                    state_next = (op_q == OP_PROG) ? VF_ISSUE : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef FLASH_CTRL_VERIFY_EN
            VF_ISSUE: begin
                state_next = VF_WAIT;
                cnt_next   = WAIT_INIT;
            end
            VF_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (fl_error) err_next = 1'b1;
                if (cnt == 4'd1) begin
                    if (fl_odata != fl_idata) err_next = 1'b1;
                    state_next = DONE;
                end
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef FLASH_CTRL_VERIFY_EN
    assign vf_pulse = (state_next == VF_ISSUE);
`else
    assign vf_pulse = 1'b0;
`endif

    // Strobes are registered from the next state so they line up with ISSUE; ack trails DONE by one edge.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state       <= RST_HOLD;
            cnt         <= WAIT_INIT;
            op_q        <= OP_NONE;
            err_acc     <= 1'b0;
            cpu_rdata   <= '0;
            cpu_ack     <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_busy    <= 1'b0;
            fl_rd_en    <= 1'b0;
            fl_wr_en    <= 1'b0;
            fl_erase_en <= 1'b0;
            fl_addr     <= '0;
            fl_idata    <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            err_acc  <= err_next;
            cpu_busy <= (state_next != IDLE);
            cpu_ack  <= (state == DONE);
            cpu_err  <= (state == DONE) && err_acc;
            if (take) begin
                op_q     <= cpu_op;
                fl_addr  <= cpu_addr;
                fl_idata <= cpu_wdata;
            end
            if (rd_capture) cpu_rdata <= fl_odata;
            fl_rd_en    <= ((state_next == ISSUE) && (cpu_op == OP_READ)) || vf_pulse;
            fl_wr_en    <= (state_next == ISSUE) && (cpu_op == OP_PROG);
            fl_erase_en <= (state_next == ISSUE) && (cpu_op == OP_ERASE);
        end
    end

endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: random and directed requests against a word-array reference model of flash_ctrl.
// Build with FLASH_CTRL_VERIFY_EN defined to exercise the program read-back verify.
module tb_flash_ctrl;

    localparam int WAIT_CYC = 3;
    localparam int ADDR_W   = 12;
    localparam int WORDS    = 1 << (ADDR_W - 2);

    logic              clk;
    logic              nRST;
    logic              cpu_req;
    logic [1:0]        cpu_op;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ack;
    logic              cpu_err;
    logic              cpu_busy;
    logic              fl_rd_en;
    logic              fl_wr_en;
    logic              fl_erase_en;
    logic [ADDR_W-1:0] fl_addr;
    logic [31:0]       fl_idata;
    logic [31:0]       fl_odata = '0;
    logic              fl_busy;
    logic              fl_error;

    int          checks      = 0;
    int          errors      = 0;
    int          strobe_viol = 0;
    logic        prev_strobe = 1'b0;
    logic        flash_init;
    logic        corrupt;
    int          err_cnt     = 0;
    logic [31:0] flash_mem [WORDS];
    logic [31:0] ref_mem   [WORDS];
    logic [31:0] exp_rdata;

    flash_ctrl #(.WAIT_CYC(WAIT_CYC), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .nRST(nRST),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .fl_rd_en(fl_rd_en), .fl_wr_en(fl_wr_en), .fl_erase_en(fl_erase_en),
        .fl_addr(fl_addr), .fl_idata(fl_idata), .fl_odata(fl_odata),
        .fl_busy(fl_busy), .fl_error(fl_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash macro: erased words read 0, programming a non-erased word raises fl_error for two cycles.
    always @(posedge clk) begin
        if (flash_init || fl_erase_en) begin
            for (int i = 0; i < WORDS; i++) flash_mem[i] <= '0;
        end else if (fl_wr_en && flash_mem[fl_addr[ADDR_W-1:2]] == '0) begin
            flash_mem[fl_addr[ADDR_W-1:2]] <= fl_idata;
        end
        if (fl_wr_en && flash_mem[fl_addr[ADDR_W-1:2]] != '0) err_cnt <= 2;
        else if (err_cnt > 0)                                  err_cnt <= err_cnt - 1;
        if (fl_rd_en) fl_odata <= flash_mem[fl_addr[ADDR_W-1:2]] ^ (corrupt ? 32'h0000_0100 : 32'h0);
    end
    assign fl_error = (err_cnt != 0);

    always @(negedge clk) begin
        if ($countones({fl_rd_en, fl_wr_en, fl_erase_en}) > 1) strobe_viol++;
        if (prev_strobe && (fl_rd_en || fl_wr_en || fl_erase_en)) strobe_viol++;
        prev_strobe = fl_rd_en || fl_wr_en || fl_erase_en;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (cpu_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (cpu_busy) checkOutput("idle_timeout", 32'(cpu_busy), 32'd0);
    endtask

    task automatic releaseReset();
        nRST = 1'b1;
        for (int i = 0; i < WAIT_CYC; i++) begin
            @(negedge clk);
            checkOutput("rst_hold_busy", 32'(cpu_busy), 32'd1);
            checkOutput("rst_hold_no_ack", 32'(cpu_ack), 32'd0);
        end
        @(negedge clk);
        checkOutput("rst_hold_exit", 32'(cpu_busy), 32'd0);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                 input logic [31:0] wdata, input int hold, input logic bad_flash);
        int                word_idx;
        bit                rejected;
        logic              exp_err;
        int                exp_lat, exp_rd, exp_wr, exp_er;
        int                lat, n_rd, n_wr, n_er;
        bit                got_ack;
        logic [ADDR_W-1:0] seen_addr;
        logic [31:0]       seen_idata;

        word_idx = int'(addr[ADDR_W-1:2]);
        rejected = (addr[1:0] != 2'b00) || (op == 2'b00);
        exp_err  = 1'b0;
        exp_lat  = WAIT_CYC + 2;
        exp_rd   = 0;
        exp_wr   = 0;
        exp_er   = 0;
        if (rejected) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else begin
            case (op)
                2'b01: begin
                    exp_rd    = 1;
                    exp_rdata = ref_mem[word_idx];
                end
                2'b10: begin
                    exp_wr  = 1;
                    exp_err = (ref_mem[word_idx] != '0);
                    if (!exp_err) ref_mem[word_idx] = wdata;
`ifdef FLASH_CTRL_VERIFY_EN
                    exp_rd  = 1;
                    exp_lat = 2 * WAIT_CYC + 3;
                    if (bad_flash) exp_err = 1'b1;
`endif
                end
                default: begin
                    exp_er = 1;
                    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
                end
            endcase
        end

        waitIdle();
        cpu_op    = op;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        corrupt   = bad_flash;
        if (hold > 0) begin
            fl_busy = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checkOutput("held_off_by_fl_busy", 32'(cpu_busy), 32'd0);
            end
            fl_busy = 1'b0;
        end
        @(posedge clk);
        lat        = 0;
        n_rd       = 0;
        n_wr       = 0;
        n_er       = 0;
        got_ack    = 1'b0;
        seen_addr  = '0;
        seen_idata = '0;
        while (!got_ack && lat < 40) begin
            @(negedge clk);
            if (lat == 0) begin
                cpu_req   = 1'b0;
                cpu_op    = 2'($urandom);
                cpu_addr  = ADDR_W'($urandom);
                cpu_wdata = $urandom;
            end
            if (fl_rd_en)    n_rd++;
            if (fl_wr_en)    n_wr++;
            if (fl_erase_en) n_er++;
            if (fl_rd_en || fl_wr_en || fl_erase_en) begin
                seen_addr  = fl_addr;
                seen_idata = fl_idata;
            end
            if (cpu_ack) got_ack = 1'b1;
            else         lat++;
        end
        checkOutput("ack_seen", 32'(got_ack), 32'd1);
        checkOutput("ack_latency", lat, exp_lat);
        checkOutput("cpu_err", 32'(cpu_err), 32'(exp_err));
        checkOutput("cpu_rdata", cpu_rdata, exp_rdata);
        checkOutput("rd_pulses", n_rd, exp_rd);
        checkOutput("wr_pulses", n_wr, exp_wr);
        checkOutput("erase_pulses", n_er, exp_er);
        if (!rejected) checkOutput("fl_addr", 32'(seen_addr), 32'(addr));
        if (op == 2'b10 && !rejected) checkOutput("fl_idata", seen_idata, wdata);
        @(negedge clk);
        checkOutput("ack_one_cycle", 32'(cpu_ack), 32'd0);
        corrupt = 1'b0;
    endtask

    initial begin
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic              bad;
        int                r;

        nRST       = 1'b0;
        cpu_req    = 1'b0;
        cpu_op     = 2'b00;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        fl_busy    = 1'b0;
        corrupt    = 1'b0;
        flash_init = 1'b1;
        exp_rdata  = '0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ack", 32'(cpu_ack), 32'd0);
        checkOutput("rst_err", 32'(cpu_err), 32'd0);
        checkOutput("rst_busy", 32'(cpu_busy), 32'd0);
        checkOutput("rst_rdata", cpu_rdata, 32'd0);
        checkOutput("rst_strobes", 32'({fl_rd_en, fl_wr_en, fl_erase_en}), 32'd0);
        checkOutput("rst_fl_addr", 32'(fl_addr), 32'd0);
        checkOutput("rst_fl_idata", fl_idata, 32'd0);
        flash_init = 1'b0;
        releaseReset();

        applyStimulus(2'b10, 12'h010, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(2'b01, 12'h010, 32'h0, 0, 1'b0);
        applyStimulus(2'b10, 12'h010, 32'h12345678, 0, 1'b0);
        applyStimulus(2'b01, 12'h010, 32'h0, 0, 1'b0);
        applyStimulus(2'b11, 12'h000, 32'h0, 0, 1'b0);
        applyStimulus(2'b01, 12'h010, 32'h0, 0, 1'b0);
        applyStimulus(2'b10, 12'h010, 32'h12345678, 0, 1'b0);
        applyStimulus(2'b01, 12'h013, 32'h0, 0, 1'b0);
        applyStimulus(2'b00, 12'h020, 32'h0, 0, 1'b0);
        applyStimulus(2'b01, 12'h010, 32'h0, 4, 1'b0);

        waitIdle();
        cpu_op   = 2'b01;
        cpu_addr = 12'h010;
        cpu_req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        nRST = 1'b0;
        #1;
        exp_rdata = '0;
        checkOutput("midrst_strobes", 32'({fl_rd_en, fl_wr_en, fl_erase_en}), 32'd0);
        checkOutput("midrst_ack", 32'(cpu_ack), 32'd0);
        checkOutput("midrst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        checkOutput("midrst_no_ack", 32'(cpu_ack), 32'd0);
        releaseReset();
        applyStimulus(2'b01, 12'h010, 32'h0, 0, 1'b0);

`ifdef FLASH_CTRL_VERIFY_EN
        applyStimulus(2'b10, 12'h020, 32'hCAFEF00D, 0, 1'b1);
        applyStimulus(2'b01, 12'h020, 32'h0, 0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      op = 2'b00;
            else if (r == 1) op = 2'b11;
            else if (r <= 8) op = 2'b01;
            else             op = 2'b10;
            addr = ADDR_W'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            bad = 1'b0;
`ifdef FLASH_CTRL_VERIFY_EN
            bad = (op == 2'b10) && ($urandom_range(0, 5) == 0);
`endif
            applyStimulus(op, addr, $urandom, $urandom_range(0, 2), bad);
        end

        checkOutput("strobe_rules", strobe_viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_ctrl.md
Name: flash_ctrl

Overview:
- Initiator-side sequencer that drives the on-chip flash macro's rd_en/wr_en/erase_en command interface on behalf of the CPU memory stage.
- Accepts one CPU request at a time (read, program, erase), issues a single-cycle flash command and waits a fixed settle window while watching flash busy/error.
- Returns the result with a one-cycle ack, and rejects misaligned or invalid requests locally without touching flash.

Parameters:
- WAIT_CYC, 3, settle cycles after each flash command pulse before the result is taken (legal range 2..15).
- ADDR_W, 12, byte address width (word address = addr[ADDR_W-1:2]).

Ports:
- clk  in  1  system clock, all logic on posedge
- nRST  in  1  asynchronous active-low reset
- cpu_req  in  1  request strobe, sampled only when cpu_busy=0
- cpu_op  in  2  01=read, 10=program, 11=erase, 00=invalid
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  32  program data
- cpu_rdata  out  32  read data, valid with cpu_ack, held until next read ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  valid with cpu_ack, 1=operation failed
- cpu_busy  out  1  high whenever state != IDLE
- fl_rd_en / fl_wr_en / fl_erase_en  out  1 each  flash command pulses, registered
- fl_addr  out  ADDR_W  latched byte address
- fl_idata  out  32  latched program data
- fl_odata  in  32  flash read data
- fl_busy  in  1  flash busy
- fl_error  in  1  flash error flag

Behaviour:
- Reset (nRST low, async): every output 0, state RST_HOLD, wait counter loaded with WAIT_CYC.
- Flash has no reset and may be mid-operation, so the block holds off in RST_HOLD for WAIT_CYC cycles after nRST deasserts; cpu_busy=1 throughout.
- States: RST_HOLD, IDLE, ISSUE, WAIT, VF_ISSUE, VF_WAIT, DONE.
- IDLE: cpu_req=1 and fl_busy=0 → latch op, addr, wdata; clear the error accumulator.
  - cpu_addr[1:0]!=0 or op=00 → DONE with err=1; no flash command is issued.
  - Otherwise → ISSUE.
  - cpu_req=1 with fl_busy=1 → stay in IDLE, request not taken; the CPU must hold cpu_req.
- ISSUE (1 cycle): exactly one of fl_rd_en/fl_wr_en/fl_erase_en high per the latched op. fl_addr and fl_idata are stable from ISSUE through DONE. → WAIT with counter=WAIT_CYC.
- WAIT: decrement the counter each cycle; any cycle with fl_error=1 sets the sticky error accumulator.
  - At counter==1, a read captures fl_odata into cpu_rdata, then → DONE (or → VF_ISSUE for program under the optional feature).
- DONE (1 cycle): cpu_ack=1, cpu_err=accumulator → IDLE.
- Latency from the accept edge to cpu_ack high:
  - Valid read/program/erase: WAIT_CYC+2 cycles.
  - Rejected request: 1 cycle.
- cpu_req during any non-IDLE state is ignored; requests are not queued.
- Command strobes are never high in two consecutive cycles and are never high together.
- A program that gets fl_error (target word not erased) completes with err=1; cpu_rdata is unchanged.
- Erase always clears the whole array; cpu_addr must still be word-aligned.
- nRST asserted mid-operation: strobes drop immediately, no ack is produced, and the block re-enters RST_HOLD.

Optional Feature:
- Macro: FLASH_CTRL_VERIFY_EN.
- Defined: after a program's WAIT, VF_ISSUE pulses fl_rd_en at the same address, then VF_WAIT runs WAIT_CYC cycles and captures fl_odata.
  - Captured data != latched wdata, or fl_error during VF_WAIT → err=1.
  - Program latency becomes 2*WAIT_CYC+3 cycles.
  - cpu_rdata is not updated by the verify read.
- Undefined: VF_* states are absent; a program completes straight after WAIT.

Test Plan:
- Reset, then program 0xDEADBEEF at addr 0x010 (word pre-erased) with WAIT_CYC=3 → single fl_wr_en pulse, fl_idata=0xDEADBEEF, cpu_ack 5 cycles after accept, err=0.
- Read addr 0x010 → one fl_rd_en pulse, cpu_rdata=0xDEADBEEF with ack 5 cycles after accept, err=0.
- Program 0x12345678 to 0x010 again (not erased, flash raises fl_error) → ack with err=1; read back still returns 0xDEADBEEF.
- Erase, then read 0x010 → 0x00000000 with err=0; program 0x12345678 now succeeds (err=0).
- Request at addr 0x013, or op=00 → ack 1 cycle after accept, err=1, no fl_* strobe ever asserted.
- fl_busy held high for 4 cycles while cpu_req=1 → no accept until fl_busy falls.
- Pulse nRST during WAIT → strobes 0, no ack, cpu_busy=1 for WAIT_CYC cycles after release.
- With FLASH_CTRL_VERIFY_EN: program is followed by a verify read; a flash model forced to return a corrupted word gives err=1, and ack arrives 9 cycles after accept.
